mips_cpu_bus_adapter: RTL and testbench

MIPS_CPU_BUS_ADAPTER -- requirements
Module: mips_cpu_bus_adapter

---
 rtl/mips_cpu_bus_pkg.sv | 39 +++
 rtl/mips_cpu_bus_lane.sv | 54 +++++
 rtl/mips_cpu_bus_adapter.sv | 215 +++++++++++++++++++++
 tb/tb_mips_cpu_bus_adapter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the MIPS CPU to Avalon-MM bus adapter.
//   size_e  : access width encoding carried on req_size
//   state_e : adapter FSM states (also exposed on the dbg_state port)
//   DEFAULT_TIMEOUT_CYCLES : default waitrequest budget, only meaningful
//                            when MIPS_CPU_BUS_TIMEOUT_EN is defined
//   access_misaligned()    : true when a request must be rejected without
//                            touching the bus
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Reserved size is always rejected; halves need even, words need
  // word-aligned addresses.
  function automatic logic access_misaligned(input size_e size,
                                             input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = |addr_lo;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_cpu_bus_lane.sv
// Little-endian lane steering for the bus adapter (purely combinational).
//   size, addr_lo : access width and byte offset within the 32-bit word
//   is_signed     : sign-extend narrow loads instead of zero-extending
//   wdata         : right-aligned store data from the CPU
//   rdata_raw     : full bus word returned by the slave
//   byteenable    : Avalon byte lanes touched by the access
//   wdata_lanes   : store data replicated into every lane
//   rdata_ext     : selected load lane(s), extended to 32 bits
module mips_cpu_bus_lane
  import mips_cpu_bus_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte k lives at [8k+7:8k]; halves only ever sit at offset 0 or 2.
  assign byte_sel = rdata_raw[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata_raw[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    byteenable  = 4'b0000;
    wdata_lanes = wdata;
    rdata_ext   = rdata_raw;
    case (size)
      SIZE_BYTE: begin
        byteenable  = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{is_signed & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        byteenable  = 4'b0011 << addr_lo;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{is_signed & half_sel[15]}}, half_sel};
      end
      SIZE_WORD: begin
        byteenable = 4'b1111;
      end
      default: begin
        byteenable = 4'b0000;
        rdata_ext  = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_adapter.sv
// Adapts a single-outstanding MIPS load/store request port to an
// Avalon-MM master. One request at a time: IDLE accepts, BUS holds the
// strobe until waitrequest drops, DONE pulses resp_valid for one cycle.
//   clk, reset      : clock, synchronous active-high reset
//   req_*           : CPU request (sampled only while req_ready=1)
//   resp_*          : one-cycle completion with extended load data / error
//   avm_*           : Avalon-MM master (registered outputs)
//   dbg_state       : current FSM state, for observation only
// Optional feature: define MIPS_CPU_BUS_TIMEOUT_EN to abort a transfer
// after TIMEOUT_CYCLES consecutive waitrequest-high cycles in BUS.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1; a bus transfer completes on a rising edge in BUS where
// the strobe is high and avm_waitrequest=0.
module mips_cpu_bus_adapter
  import mips_cpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_write_q, avm_write_d;
  logic [31:0] avm_address_q, avm_address_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;
  logic [3:0]  avm_byteenable_q, avm_byteenable_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;

  // Captured request fields needed after IDLE (address and store data
  // live in the avm_* registers themselves).
  size_e       cap_size_q, cap_size_d;
  logic        cap_signed_q, cap_signed_d;
  logic [1:0]  cap_addr_lo_q, cap_addr_lo_d;

  size_e       req_size_e;
  size_e       lane_size;
  logic [1:0]  lane_addr_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

`ifdef MIPS_CPU_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
`endif

  assign req_size_e = size_e'(req_size);

  // One lane unit serves both phases: in IDLE it shapes the incoming
  // store, afterwards it extracts the load using the captured fields.
  assign lane_size    = (state_q == ST_IDLE) ? req_size_e : cap_size_q;
  assign lane_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0] : cap_addr_lo_q;

  mips_cpu_bus_lane u_lane (
    .size        (lane_size),
    .addr_lo     (lane_addr_lo),
    .is_signed   (cap_signed_q),
    .wdata       (req_wdata),
    .rdata_raw   (avm_readdata),
    .byteenable  (lane_be),
    .wdata_lanes (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

  always_comb begin
    state_d          = state_q;
    avm_read_d       = avm_read_q;
    avm_write_d      = avm_write_q;
    avm_address_d    = avm_address_q;
    avm_writedata_d  = avm_writedata_q;
    avm_byteenable_d = avm_byteenable_q;
    cap_size_d       = cap_size_q;
    cap_signed_d     = cap_signed_q;
    cap_addr_lo_d    = cap_addr_lo_q;
    // Response fields are a pulse: cleared unless this edge completes.
    resp_valid_d     = 1'b0;
    resp_rdata_d     = 32'h0;
    resp_error_d     = 1'b0;
`ifdef MIPS_CPU_BUS_TIMEOUT_EN
    timeout_cnt_d    = timeout_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cap_size_d    = req_size_e;
          cap_signed_d  = req_signed;
          cap_addr_lo_d = req_addr[1:0];
          if (access_misaligned(req_size_e, req_addr[1:0])) begin
            // Rejected without a bus cycle.
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d          = ST_BUS;
            avm_address_d    = {req_addr[31:2], 2'b00};
            avm_writedata_d  = lane_wdata;
            avm_byteenable_d = lane_be;
            avm_read_d       = ~req_write;
            avm_write_d      = req_write;
`ifdef MIPS_CPU_BUS_TIMEOUT_EN
            timeout_cnt_d    = '0;
`endif
          end
        end
      end

      ST_BUS: begin
        if (!avm_waitrequest) begin
          state_d      = ST_DONE;
          avm_read_d   = 1'b0;
          avm_write_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = avm_write_q ? 32'h0 : lane_rdata;
        end
`ifdef MIPS_CPU_BUS_TIMEOUT_EN
        else begin
          timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
          if (timeout_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d      = ST_DONE;
            avm_read_d   = 1'b0;
            avm_write_d  = 1'b0;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        avm_read_d  = 1'b0;
        avm_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_address_q    <= 32'h0;
      avm_writedata_q  <= 32'h0;
      avm_byteenable_q <= 4'b0000;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= 32'h0;
      resp_error_q     <= 1'b0;
      cap_size_q       <= SIZE_BYTE;
      cap_signed_q     <= 1'b0;
      cap_addr_lo_q    <= 2'b00;
`ifdef MIPS_CPU_BUS_TIMEOUT_EN
      timeout_cnt_q    <= '0;
`endif
    end else begin
      state_q          <= state_d;
      avm_read_q       <= avm_read_d;
      avm_write_q      <= avm_write_d;
      avm_address_q    <= avm_address_d;
      avm_writedata_q  <= avm_writedata_d;
      avm_byteenable_q <= avm_byteenable_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_error_q     <= resp_error_d;
      cap_size_q       <= cap_size_d;
      cap_signed_q     <= cap_signed_d;
      cap_addr_lo_q    <= cap_addr_lo_d;
`ifdef MIPS_CPU_BUS_TIMEOUT_EN
      timeout_cnt_q    <= timeout_cnt_d;
`endif
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;
  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = avm_byteenable_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mips_cpu_bus_adapter.sv
// Bench for mips_cpu_bus_adapter: a vector table of single requests,
// hand-written reset-in-BUS and (with MIPS_CPU_BUS_TIMEOUT_EN) timeout
// sequences, and random word loads. Responses are checked by a monitor
// against an expected queue of {error, rdata}.
module tb_mips_cpu_bus_adapter;
  import mips_cpu_bus_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  state_e      dbg_state;

  int total;
  int bad;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;

  mips_cpu_bus_adapter #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int waits, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.waits = waits; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  // ---------------- checkers ----------------
  task automatic chk32(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, 32'(act), 32'(exp));
  endtask

  // Response monitor: every resp_valid pulse must match the oldest
  // expected response; a pulse with nothing expected is an error.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 want none (rdata=%h err=%b)",
                 resp_rdata, resp_error);
      end else begin
        mon_exp = exp_q.pop_front();
        chk1("resp_error", resp_error, mon_exp[32]);
        chk32("resp_rdata", resp_rdata, mon_exp[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk1({tag, ".ready_wait"}, req_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    wait_ready(tag);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(posedge clk);               // accept edge N
    @(negedge clk);               // cycle N+1
    // Conflicting request while busy; the adapter must ignore it.
    req_addr  = 32'hFFFF_FFF4;
    req_write = ~v.wr;
    req_size  = 2'd0;
    req_wdata = $urandom;
    if (v.exp_err) begin
      chk1({tag, ".err_no_read"}, avm_read, 1'b0);
      chk1({tag, ".err_no_write"}, avm_write, 1'b0);
      chk1({tag, ".err_resp_at_n1"}, resp_valid, 1'b1);
      req_valid = 1'b0;
      @(negedge clk);
      chk1({tag, ".err_ready_back"}, req_ready, 1'b1);
      chk1({tag, ".err_still_no_strobe"}, avm_read | avm_write, 1'b0);
    end else begin
      for (int c = 0; c <= v.waits; c++) begin
        if (c > 0) @(negedge clk);
        chk1({tag, ".read"}, avm_read, ~v.wr);
        chk1({tag, ".write"}, avm_write, v.wr);
        chk32({tag, ".address"}, avm_address, {v.addr[31:2], 2'b00});
        chk32({tag, ".byteenable"}, 32'(avm_byteenable), 32'(v.exp_be));
        if (v.wr) chk32({tag, ".writedata"}, avm_writedata, v.exp_wdata);
        avm_waitrequest = (c < v.waits);
        avm_readdata    = (c < v.waits) ? $urandom : v.rdata;
      end
      @(negedge clk);             // DONE cycle
      req_valid = 1'b0;
      chk1({tag, ".strobe_drop"}, avm_read | avm_write, 1'b0);
      chk1({tag, ".resp_timing"}, resp_valid, 1'b1);
      @(negedge clk);
      chk1({tag, ".ready_back"}, req_ready, 1'b1);
      chk1({tag, ".resp_one_cycle"}, resp_valid, 1'b0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t rv;
    total = 0;
    bad = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    avm_waitrequest = 1'b0; avm_readdata = 32'h0;

    //            wr   size sgn  addr          wdata         rdata         w  be       exp_wdata     exp_rdata     err
    vecs[0]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0);
    vecs[1]  = mk(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    vecs[2]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 0, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
    vecs[3]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h0000_ABCD, 32'h0,       3, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
    vecs[4]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1);
    vecs[5]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h1234_565A, 32'h0,       1, 4'b0010, 32'h5A5A_5A5A, 32'h0,        1'b0);
    vecs[6]  = mk(1'b0, 2'd1, 1'b1, 32'h0000_3000, 32'h0,        32'h1234_8765, 2, 4'b0011, 32'h0,        32'hFFFF_8765, 1'b0);
    vecs[7]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_3002, 32'h0,        32'h1234_8765, 0, 4'b1100, 32'h0,        32'h0000_1234, 1'b0);
    vecs[8]  = mk(1'b0, 2'd1, 1'b0, 32'h0000_3003, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1);
    vecs[9]  = mk(1'b0, 2'd3, 1'b0, 32'h0000_4000, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1);
    vecs[10] = mk(1'b1, 2'd2, 1'b0, 32'h0000_4008, 32'hCAFE_F00D, 32'h0,       0, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0);
    vecs[11] = mk(1'b0, 2'd0, 1'b1, 32'h0000_4001, 32'h0,        32'h0000_7F00, 1, 4'b0010, 32'h0,        32'h0000_007F, 1'b0);
    vecs[12] = mk(1'b1, 2'd1, 1'b0, 32'h0000_4001, 32'h0000_1111, 32'h0,       0, 4'b0000, 32'h0,        32'h0,        1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst.req_ready", req_ready, 1'b1);
    chk32("rst.state", 32'(dbg_state), 32'(ST_IDLE));
    chk1("rst.read", avm_read, 1'b0);
    chk1("rst.write", avm_write, 1'b0);
    chk32("rst.address", avm_address, 32'h0);
    chk32("rst.writedata", avm_writedata, 32'h0);
    chk32("rst.byteenable", 32'(avm_byteenable), 32'h0);
    chk1("rst.resp_valid", resp_valid, 1'b0);
    chk32("rst.resp_rdata", resp_rdata, 32'h0);
    chk1("rst.resp_error", resp_error, 1'b0);
    reset = 1'b0;

    // Table vectors
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting in BUS: no response, request discarded.
    wait_ready("rst_bus");
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_6000;
    avm_waitrequest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk1("rst_bus.read_high", avm_read, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk1("rst_bus.read_low", avm_read, 1'b0);
    chk1("rst_bus.write_low", avm_write, 1'b0);
    chk1("rst_bus.no_resp", resp_valid, 1'b0);
    chk1("rst_bus.ready", req_ready, 1'b1);
    avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_bus.idle_after", req_ready, 1'b1);

`ifdef MIPS_CPU_BUS_TIMEOUT_EN
    begin
      int hi_cycles;
      wait_ready("timeout");
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_5000;
      avm_waitrequest = 1'b1;
      exp_q.push_back({1'b1, 32'h0});
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      hi_cycles = 0;
      while (avm_read && hi_cycles < 100) begin
        hi_cycles++;
        @(negedge clk);
      end
      chk32("timeout.strobe_cycles", 32'(hi_cycles), 32'd8);
      chk1("timeout.resp_valid", resp_valid, 1'b1);
      @(negedge clk);
      chk1("timeout.ready", req_ready, 1'b1);
      avm_waitrequest = 1'b0;
    end
`endif

    // Random aligned word loads with random wait states.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rd;
      ra = {$urandom_range(0, 16'hFFFF), 2'b00};
      rd = $urandom;
      rv = mk(1'b0, 2'd2, 1'($urandom_range(0, 1)), ra, 32'h0, rd,
              int'($urandom_range(0, 3)), 4'b1111, 32'h0, rd, 1'b0);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    repeat (3) @(negedge clk);
    chk32("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
